// File: rtl/hw2_pkg.sv
// Shared constants and the group-entry record for the result accumulator.
// Entries are sized for the largest legal ACC_LEN so one struct serves every instance.
package hw2_pkg;

  localparam int DATA_W         = 16;
  localparam int ACC_LEN_DEF    = 4;
  localparam int FIFO_DEPTH_DEF = 4;
  localparam int CNT_W          = 5;
  localparam int ACC_LEN_MAX    = 16;

  function automatic int sum_w(input int acc_len);
    return DATA_W + $clog2(acc_len);
  endfunction

  localparam int SUM_W     = sum_w(ACC_LEN_DEF);
  localparam int SUM_W_MAX = sum_w(ACC_LEN_MAX);

  typedef struct packed {
    logic [SUM_W_MAX-1:0] sum;
    logic [CNT_W-1:0]     cnt;
  } grp_entry_t;

endpackage

// File: rtl/hw2_sync_fifo.sv
// Synchronous FIFO with level output; a push while full is accepted only
// when a pop happens on the same edge.
module hw2_sync_fifo
  import hw2_pkg::*;
#(
  parameter int WIDTH = $bits(grp_entry_t),
  parameter int DEPTH = FIFO_DEPTH_DEF,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level
);

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             do_wr, do_rd;

  assign full  = (cnt_q == (AW+1)'(DEPTH));
  assign empty = (cnt_q == '0);
  assign level = cnt_q;
  assign rdata = mem_q[rd_ptr_q];

  assign do_rd = pop && !empty;
  assign do_wr = push && (!full || do_rd);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    // Pointers are AW bits wide, so increments wrap modulo DEPTH.
    if (do_wr) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_rd) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_wr, do_rd})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset: occupancy gates every read.
  always_ff @(posedge CLK) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/hw2_result_accum.sv
// Sums groups of upstream pipeline results and buffers completed sums in a FIFO.
// A group closes after ACC_LEN samples or early on in_last.
module hw2_result_accum
  import hw2_pkg::*;
#(
  parameter int ACC_LEN    = ACC_LEN_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  localparam int SUM_W     = sum_w(ACC_LEN)
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [15:0]      in_d,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SUM_W-1:0] out_sum,
  output logic [4:0]       out_cnt,
  output logic [4:0]       fifo_level,
  output logic             ovf
);

  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  logic [SUM_W-1:0] acc_q, acc_d, acc_nxt;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             complete, pop;
  logic             f_full, f_empty;
  logic [LW-1:0]    f_level;
  grp_entry_t       wr_ent, rd_ent;

  assign acc_nxt  = acc_q + SUM_W'(in_d);
  assign complete = in_valid && ((cnt_q == CNT_W'(ACC_LEN-1)) || in_last);
  assign pop      = out_valid && out_ready;

  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    if (in_valid) begin
      acc_d = complete ? '0 : acc_nxt;
      cnt_d = complete ? '0 : cnt_q + 1'b1;
    end
  end

  always_comb begin
    wr_ent                = '0;
    wr_ent.sum[SUM_W-1:0] = acc_nxt;
    wr_ent.cnt            = cnt_q + 1'b1;
  end

  // A full FIFO with no simultaneous pop drops the group; the sticky flag records it.
  assign ovf_d = ovf_q || (complete && f_full && !pop);

  always_ff @(posedge CLK) begin
    if (!reset) begin
      acc_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  hw2_sync_fifo #(
    .WIDTH ($bits(grp_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .CLK   (CLK),
    .reset (reset),
    .push  (complete),
    .wdata (wr_ent),
    .pop   (pop),
    .rdata (rd_ent),
    .full  (f_full),
    .empty (f_empty),
    .level (f_level)
  );

  // Outputs are forced to zero while reset is held so no stale storage leaks out.
  assign out_valid  = reset && !f_empty;
  assign out_sum    = out_valid ? rd_ent.sum[SUM_W-1:0] : '0;
  assign out_cnt    = out_valid ? rd_ent.cnt : '0;
  assign fifo_level = 5'(f_level);
  assign ovf        = ovf_q;

endmodule

// File: tb/tb_hw2_result_accum.sv
// Directed scoreboard bench: stimulus pushes hand-computed group results,
// a negedge monitor pops and compares on every accepted output.
module tb_hw2_result_accum;

  logic        CLK = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [15:0] in_d;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [17:0] out_sum;
  logic [4:0]  out_cnt;
  logic [4:0]  fifo_level;
  logic        ovf;

  int n_checks = 0;
  int n_fail   = 0;
  logic [22:0] exp_q[$];

  always #5 CLK = ~CLK;

  hw2_result_accum dut (
    .CLK        (CLK),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_d       (in_d),
    .in_last    (in_last),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_sum    (out_sum),
    .out_cnt    (out_cnt),
    .fifo_level (fifo_level),
    .ovf        (ovf)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic expect_grp(input logic [17:0] sum, input logic [4:0] cnt);
    exp_q.push_back({sum, cnt});
  endtask

  task automatic send(input logic [15:0] d, input logic last);
    in_valid = 1'b1;
    in_d     = d;
    in_last  = last;
    @(posedge CLK); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_d     = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge CLK); #1; end
  endtask

  task automatic do_reset(input int n);
    reset = 1'b0;
    exp_q.delete();
    repeat (n) @(posedge CLK);
    #1 reset = 1'b1;
  endtask

  task automatic drain(input string name);
    int k;
    out_ready = 1'b1;
    k = 0;
    while (fifo_level != 0 && k < 50) begin @(posedge CLK); #1; k++; end
    out_ready = 1'b0;
    @(negedge CLK);
    check({name, "_level0"}, 32'(fifo_level), 32'd0);
    check({name, "_sb_empty"}, 32'(exp_q.size()), 32'd0);
  endtask

  // Monitor: every accepted output must match the scoreboard head.
  initial begin
    logic [22:0] e;
    forever begin
      @(negedge CLK);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_output: got sum 0x%0h cnt %0d, expected none", out_sum, out_cnt);
        end else begin
          e = exp_q.pop_front();
          check("out_sum", 32'(out_sum), 32'(e[22:5]));
          check("out_cnt", 32'(out_cnt), 32'(e[4:0]));
        end
      end
    end
  end

  initial begin
    reset = 1'b0; in_valid = 1'b0; in_d = '0; in_last = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check("rst_out_sum", 32'(out_sum), 32'd0);
    check("rst_out_cnt", 32'(out_cnt), 32'd0);
    #1 reset = 1'b1;
    @(negedge CLK);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_level", 32'(fifo_level), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    check("rst_sum_rel", 32'(out_sum), 32'd0);
    @(posedge CLK); #1;

    // Full-length group, no same-cycle bypass.
    out_ready = 1'b1;
    expect_grp(18'h10005, 5'd4);
    send(16'h0001, 1'b0);
    send(16'h0002, 1'b0);
    send(16'h0003, 1'b0);
    in_valid = 1'b1; in_d = 16'hFFFF;
    @(negedge CLK);
    check("no_bypass_valid", 32'(out_valid), 32'd0);
    @(posedge CLK); #1;
    in_valid = 1'b0; in_d = '0;
    @(negedge CLK);
    check("lat_valid", 32'(out_valid), 32'd1);
    @(posedge CLK); #1;

    // Early close with gaps.
    expect_grp(18'h00030, 5'd2);
    send(16'h0010, 1'b0);
    idle(3);
    send(16'h0020, 1'b1);
    idle(2);

    // Maximum sum does not wrap.
    expect_grp(18'h3FFFC, 5'd4);
    repeat (4) send(16'hFFFF, 1'b0);
    // Three-sample early group.
    expect_grp(18'h00007, 5'd3);
    send(16'h0001, 1'b0); send(16'h0002, 1'b0); send(16'h0004, 1'b1);
    idle(2);
    drain("basic");

    // Overflow: 5 groups into a 4-deep FIFO with no consumer.
    for (int g = 0; g < 4; g++) expect_grp(18'h00004, 5'd4);
    for (int g = 0; g < 5; g++) repeat (4) send(16'h0001, 1'b0);
    @(negedge CLK);
    check("ovf_level", 32'(fifo_level), 32'd4);
    check("ovf_flag", 32'(ovf), 32'd1);
    check("hold_sum", 32'(out_sum), 32'h4);
    idle(3);
    @(negedge CLK);
    check("hold_sum_stable", 32'(out_sum), 32'h4);
    check("hold_cnt_stable", 32'(out_cnt), 32'd4);
    @(posedge CLK); #1;
    drain("ovf");
    check("ovf_sticky", 32'(ovf), 32'd1);

    // Push on full with simultaneous pop.
    do_reset(2);
    for (int g = 0; g < 4; g++) expect_grp(18'(4 * (g + 1)), 5'd4);
    for (int g = 0; g < 4; g++) repeat (4) send(16'(g + 1), 1'b0);
    @(negedge CLK);
    check("full_level", 32'(fifo_level), 32'd4);
    check("full_ovf", 32'(ovf), 32'd0);
    @(posedge CLK); #1;
    expect_grp(18'h00400, 5'd4);
    repeat (3) send(16'h0100, 1'b0);
    out_ready = 1'b1;
    send(16'h0100, 1'b0);
    out_ready = 1'b0;
    @(negedge CLK);
    check("pushpop_level", 32'(fifo_level), 32'd4);
    check("pushpop_ovf", 32'(ovf), 32'd0);
    @(posedge CLK); #1;
    drain("pushpop");

    // Reset mid-group discards the partial sum.
    out_ready = 1'b1;
    send(16'h0005, 1'b0);
    send(16'h0006, 1'b0);
    do_reset(1);
    expect_grp(18'h00004, 5'd4);
    repeat (4) send(16'h0001, 1'b0);
    idle(2);
    drain("midrst");

    // Reset mid-drain discards buffered sums.
    out_ready = 1'b0;
    repeat (8) send(16'h0002, 1'b0);
    do_reset(1);
    @(negedge CLK);
    check("drainrst_level", 32'(fifo_level), 32'd0);
    check("drainrst_valid", 32'(out_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
